// File: rtl/mem_txd_serializer.sv
// mem_txd_serializer
//   Pulls cfg_cnt words from a memory read stream and emits the enabled byte
//   lanes of each word, lowest lane first, on an 8-bit stream towards a UART
//   transmitter. Lanes whose keep bit is clear are skipped. A word with an
//   all-zero keep mask is consumed without emitting anything.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
//   both high. A producer holds valid and data stable until that edge. The
//   byte stream here never drops str_txd_tvalid or changes str_txd_tdata
//   while waiting for str_txd_tready. mem_tready is asserted only in FETCH.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   cfg_start      : one-cycle start pulse, honoured only in IDLE
//   cfg_cnt        : number of words to transfer, sampled with cfg_start
//   busy           : high from the cycle after an accepted start through done
//   done           : one-cycle completion pulse
//   mem_tvalid     : memory stream valid
//   mem_tdata      : memory word
//   mem_tkeep      : byte-lane enables (bit i covers bits 8i+7:8i)
//   mem_tready     : memory stream ready
//   str_txd_tvalid : byte stream valid
//   str_txd_tdata  : byte stream data
//   str_txd_tready : byte stream ready
//   dbg_state      : FSM state (0 IDLE, 1 FETCH, 2 SEND, 3 DONE)
module mem_txd_serializer #(
    parameter int MDW = 32,
    parameter int CW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CW-1:0]    cfg_cnt,
    output logic             busy,
    output logic             done,
    input  logic             mem_tvalid,
    input  logic [MDW-1:0]   mem_tdata,
    input  logic [MDW/8-1:0] mem_tkeep,
    output logic             mem_tready,
    output logic             str_txd_tvalid,
    output logic [7:0]       str_txd_tdata,
    input  logic             str_txd_tready,
    output logic [1:0]       dbg_state
);

    localparam int NB = MDW / 8;
    localparam logic [NB-1:0] LANE_ONE = NB'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   remaining;
    logic [MDW-1:0]  data_q;
    logic [NB-1:0]   mask_q;

    logic [NB-1:0]   mask_clr;
    logic [7:0]      cap_byte;
    logic [7:0]      next_byte;

    // Byte of the lowest-index enabled lane (0 when no lane is enabled).
    // Scanning downwards lets the lowest set lane win.
    function automatic logic [7:0] lowest_byte(input logic [MDW-1:0] d,
                                               input logic [NB-1:0]  m);
        lowest_byte = 8'h00;
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i]) lowest_byte = d[8*i +: 8];
        end
    endfunction

    always_comb begin
        mask_clr  = mask_q & (mask_q - LANE_ONE);  // drop lowest set lane
        cap_byte  = lowest_byte(mem_tdata, mem_tkeep);
        next_byte = lowest_byte(data_q, mask_clr);
    end

    assign dbg_state = state;

    // The first byte of a captured word is loaded straight from the memory
    // bus so it is presented in the cycle right after the word is accepted.
    // After each word, remaining is tested before the decrement: a value of
    // 1 means that word was the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            remaining      <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_tready     <= 1'b0;
            str_txd_tvalid <= 1'b0;
            str_txd_tdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        busy <= 1'b1;
                        if (cfg_cnt != '0) begin
                            remaining  <= cfg_cnt;
                            mem_tready <= 1'b1;
                            state      <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_FETCH: begin
                    if (mem_tvalid && mem_tready) begin
                        data_q <= mem_tdata;
                        mask_q <= mem_tkeep;
                        if (mem_tkeep != '0) begin
                            mem_tready     <= 1'b0;
                            str_txd_tvalid <= 1'b1;
                            str_txd_tdata  <= cap_byte;
                            state          <= S_SEND;
                        end else begin
                            remaining <= remaining - CNT_ONE;
                            if (remaining <= CNT_ONE) begin
                                mem_tready <= 1'b0;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end
                        end
                    end
                end

                S_SEND: begin
                    if (str_txd_tvalid && str_txd_tready) begin
                        mask_q <= mask_clr;
                        if (mask_clr != '0) begin
                            str_txd_tdata <= next_byte;
                        end else begin
                            str_txd_tvalid <= 1'b0;
                            remaining      <= remaining - CNT_ONE;
                            if (remaining > CNT_ONE) begin
                                mem_tready <= 1'b1;
                                state      <= S_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
